// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid pipeline stage with flush and bubble-cleared control
// Optional saturating stall/flush counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   head_data_q, head_data_d;
    logic [CTRL_W-1:0]   head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic                accept;
    logic                drain;

    // Handshake outputs depend on the state register only, never on out_ready.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_data_q;
    assign out_ctrl  = head_ctrl_q;
    assign occupancy = 2'(state_q);

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ctrl_d = head_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            // Payload is kept for debug visibility; only control is squashed.
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        head_data_d = in_data;
                        head_ctrl_d = in_ctrl;
                    end else if (accept) begin
                        state_d     = ST_FULL;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (drain) begin
                        state_d     = ST_EMPTY;
                        head_ctrl_d = '0;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d     = ST_ONE;
                        head_data_d = skid_data_q;
                        head_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    head_ctrl_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ctrl_q <= head_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
    localparam int DATA_W = 96;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t sb[$];
    int     n_cmp  = 0;
    int     n_fail = 0;
    bit     done   = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per drain and checks the bubble rule every cycle.
    always @(negedge CLK) begin
        if (!done && nRST) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data 0x%0h ctrl 0x%0h expected nothing", out_data, out_ctrl);
                end else begin
                    entry_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_ctrl", DATA_W'(out_ctrl), DATA_W'(e.ctrl));
                end
            end
            if (!out_valid)
                check("bubble_ctrl", DATA_W'(out_ctrl), '0);
        end
    end

    // One cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
        entry_t e;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        if (v && in_ready && !fl) begin
            e.data = d;
            e.ctrl = c;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_occupancy", DATA_W'(occupancy), 0);
        check("rst_in_ready", DATA_W'(in_ready), 1);
        check("rst_out_valid", DATA_W'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ctrl", DATA_W'(out_ctrl), 0);
        check("rst_stall_cnt", DATA_W'(stall_cnt), 0);
        nRST = 1'b1;

        // Streaming at full rate with 1-cycle latency and no gaps.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, DATA_W'(i), CTRL_W'(i), 1'b1, 1'b0);
            check("stream_valid", DATA_W'(out_valid), 1);
            check("stream_occ", DATA_W'(occupancy), 1);
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_end_valid", DATA_W'(out_valid), 0);

        // Backpressure fills the skid entry; C waits for space.
        cyc(1'b1, 96'hA, 8'h11, 1'b0, 1'b0);
        check("bp_occ1", DATA_W'(occupancy), 1);
        cyc(1'b1, 96'hB, 8'h22, 1'b0, 1'b0);
        check("bp_occ2", DATA_W'(occupancy), 2);
        check("bp_in_ready", DATA_W'(in_ready), 0);
        cyc(1'b1, 96'hC, 8'h33, 1'b0, 1'b0);
        check("bp_hold_data", out_data, 96'hA);
        check("bp_hold_ctrl", DATA_W'(out_ctrl), 8'h11);
        cyc(1'b1, 96'hC, 8'h33, 1'b1, 1'b0);
        cyc(1'b1, 96'hC, 8'h33, 1'b1, 1'b0);
        check("bp_occ_c", DATA_W'(occupancy), 1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("bp_drained", DATA_W'(occupancy), 0);

        // Flush while FULL with all control bits set.
        cyc(1'b1, 96'hE, 8'hFF, 1'b0, 1'b0);
        cyc(1'b1, 96'hF, 8'hFF, 1'b0, 1'b0);
        check("fl_full", DATA_W'(occupancy), 2);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        sb.delete();
        check("fl_valid", DATA_W'(out_valid), 0);
        check("fl_ctrl", DATA_W'(out_ctrl), 0);
        check("fl_occ", DATA_W'(occupancy), 0);
        check("fl_in_ready", DATA_W'(in_ready), 1);
        check("fl_data_held", out_data, 96'hE);
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall_4", DATA_W'(stall_cnt), 4);
        check("perf_flush_1", DATA_W'(flush_cnt), 1);
`else
        check("perf_off_stall", DATA_W'(stall_cnt), 0);
        check("perf_off_flush", DATA_W'(flush_cnt), 0);
`endif

        // Accept coinciding with flush is dropped.
        cyc(1'b1, 96'hD, 8'h5A, 1'b1, 1'b1);
        check("drop_valid", DATA_W'(out_valid), 0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("drop_valid2", DATA_W'(out_valid), 0);

        // Long stall saturates the counter.
        cyc(1'b1, 96'h9, 8'h09, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check("perf_stall_sat", DATA_W'(stall_cnt), 15);
`else
        check("perf_off_stall2", DATA_W'(stall_cnt), 0);
`endif
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("sat_drained", DATA_W'(occupancy), 0);

        // Asynchronous reset while FULL.
        cyc(1'b1, 96'h77, 8'h7F, 1'b0, 1'b0);
        cyc(1'b1, 96'h88, 8'h8F, 1'b0, 1'b0);
        check("ar_full", DATA_W'(occupancy), 2);
        nRST = 1'b0;
        #1;
        sb.delete();
        check("ar_valid", DATA_W'(out_valid), 0);
        check("ar_ctrl", DATA_W'(out_ctrl), 0);
        check("ar_occ", DATA_W'(occupancy), 0);
        check("ar_in_ready", DATA_W'(in_ready), 1);
        check("ar_stall_cnt", DATA_W'(stall_cnt), 0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        check("sb_empty", DATA_W'(sb.size()), 0);
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
